// File: rtl/eth_udp_regs_pkg.sv
// Shared register map, bit positions and config bundle type for the Ethernet/UDP register block.
package eth_udp_regs_pkg;

  localparam logic [4:0] REG_CTRL      = 5'h00;
  localparam logic [4:0] REG_MAC_LO    = 5'h04;
  localparam logic [4:0] REG_MAC_HI    = 5'h08;
  localparam logic [4:0] REG_LOCAL_IP  = 5'h0C;
  localparam logic [4:0] REG_REMOTE_IP = 5'h10;
  localparam logic [4:0] REG_PORTS     = 5'h14;
  localparam logic [4:0] REG_STATUS    = 5'h18;
  localparam logic [4:0] REG_COUNTS    = 5'h1C;

  // Words 0..5 are plain read/write configuration storage.
  localparam int CFG_WORDS = 6;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_LOOPBACK_BIT = 1;
  localparam int CTRL_SOFT_RST_BIT = 31;

  localparam int STAT_LINK_UP_BIT = 0;
  localparam int STAT_ARP_BIT     = 1;
  localparam int STAT_RX_OVF_BIT  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  typedef struct packed {
    logic        enable;
    logic        loopback;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [31:0] remote_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } cfg_t;

  function automatic int word_idx(input logic [4:0] off);
    return int'(off[4:2]);
  endfunction

  // Bits that physically exist in each storage word; the rest read back as 0.
  function automatic logic [31:0] cfg_word_mask(input int idx);
    case (idx)
      0:       return 32'h0000_0003;
      2:       return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/eth_udp_evt_cnt.sv
// Wrapping event counter with synchronous clear; an event coinciding with clear yields 1.
module eth_udp_evt_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= WIDTH'(inc);
    end else if (inc) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/eth_udp_axil_regs.sv
// AXI4-Lite register file configuring the Ethernet/ARP/UDP stack and reporting its status.
// Define ETH_UDP_REGS_STATS_EN to add the tx/rx packet counters read through COUNTS.
module eth_udp_axil_regs
  import eth_udp_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              cfg_enable,
  output logic                              cfg_loopback,
  output logic                              cfg_soft_rst,
  output logic [47:0]                       cfg_local_mac,
  output logic [31:0]                       cfg_local_ip,
  output logic [31:0]                       cfg_remote_ip,
  output logic [15:0]                       cfg_src_port,
  output logic [15:0]                       cfg_dst_port,
  input  logic                              st_link_up,
  input  logic                              st_arp_resolved,
  input  logic                              ev_rx_overflow,
  input  logic                              ev_tx_pkt,
  input  logic                              ev_rx_pkt
);

  // ---------------- write channel ----------------
  wr_state_t                        wr_state_reg, wr_state_next;
  logic                             aw_latched_reg, aw_latched_next;
  logic                             w_latched_reg, w_latched_next;
  logic [C_S_AXI_ADDR_WIDTH-1:0]    awaddr_reg, awaddr_next;
  logic [31:0]                      wdata_reg, wdata_next;
  logic [3:0]                       wstrb_reg, wstrb_next;
  logic                             awready_reg, awready_next;
  logic                             wready_reg, wready_next;
  logic                             bvalid_reg, bvalid_next;
  logic                             do_write;

  always_comb begin
    wr_state_next   = wr_state_reg;
    aw_latched_next = aw_latched_reg;
    w_latched_next  = w_latched_reg;
    awaddr_next     = awaddr_reg;
    wdata_next      = wdata_reg;
    wstrb_next      = wstrb_reg;
    bvalid_next     = bvalid_reg;
    do_write        = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_reg) begin
          aw_latched_next = 1'b1;
          awaddr_next     = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && wready_reg) begin
          w_latched_next = 1'b1;
          wdata_next     = S_AXI_WDATA;
          wstrb_next     = S_AXI_WSTRB;
        end
        // Commit only once both halves sit in the latches.
        if (aw_latched_reg && w_latched_reg) begin
          do_write      = 1'b1;
          bvalid_next   = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_next     = 1'b0;
          aw_latched_next = 1'b0;
          w_latched_next  = 1'b0;
          wr_state_next   = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
    awready_next = (wr_state_next == W_IDLE) && !aw_latched_next;
    wready_next  = (wr_state_next == W_IDLE) && !w_latched_next;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_reg   <= W_IDLE;
      aw_latched_reg <= 1'b0;
      w_latched_reg  <= 1'b0;
      awaddr_reg     <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
    end else begin
      wr_state_reg   <= wr_state_next;
      aw_latched_reg <= aw_latched_next;
      w_latched_reg  <= w_latched_next;
      awaddr_reg     <= awaddr_next;
      wdata_reg      <= wdata_next;
      wstrb_reg      <= wstrb_next;
      awready_reg    <= awready_next;
      wready_reg     <= wready_next;
      bvalid_reg     <= bvalid_next;
    end
  end

  logic [2:0] wr_idx;
  logic [4:0] wr_off;
  assign wr_idx = awaddr_reg[4:2];
  assign wr_off = {wr_idx, 2'b00};

  // ---------------- configuration storage ----------------
  logic [31:0] word_val [CFG_WORDS];

  genvar gi;
  for (gi = 0; gi < CFG_WORDS; gi++) begin : g_cfg_word
    logic [31:0] word_reg;
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        word_reg <= '0;
      end else if (do_write && (wr_idx == 3'(gi))) begin
        word_reg <= strb_merge(word_reg, wdata_reg, wstrb_reg) & cfg_word_mask(gi);
      end
    end
    assign word_val[gi] = word_reg;
  end

  logic soft_rst_reg;
  logic rx_ovf_reg;
  logic ovf_clr;
  logic cnt_clr;

  assign ovf_clr = do_write && (wr_off == REG_STATUS) && wstrb_reg[0] && wdata_reg[STAT_RX_OVF_BIT];
  assign cnt_clr = do_write && (wr_off == REG_COUNTS);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      soft_rst_reg <= 1'b0;
      rx_ovf_reg   <= 1'b0;
    end else begin
      soft_rst_reg <= do_write && (wr_off == REG_CTRL) && wstrb_reg[3] && wdata_reg[CTRL_SOFT_RST_BIT];
      // A new overflow event outranks a simultaneous W1C.
      rx_ovf_reg   <= ev_rx_overflow || (rx_ovf_reg && !ovf_clr);
    end
  end

  cfg_t cfg;
  assign cfg.enable    = word_val[word_idx(REG_CTRL)][CTRL_ENABLE_BIT];
  assign cfg.loopback  = word_val[word_idx(REG_CTRL)][CTRL_LOOPBACK_BIT];
  assign cfg.local_mac = {word_val[word_idx(REG_MAC_HI)][15:0], word_val[word_idx(REG_MAC_LO)]};
  assign cfg.local_ip  = word_val[word_idx(REG_LOCAL_IP)];
  assign cfg.remote_ip = word_val[word_idx(REG_REMOTE_IP)];
  assign cfg.src_port  = word_val[word_idx(REG_PORTS)][31:16];
  assign cfg.dst_port  = word_val[word_idx(REG_PORTS)][15:0];

  assign cfg_enable    = cfg.enable;
  assign cfg_loopback  = cfg.loopback;
  assign cfg_local_mac = cfg.local_mac;
  assign cfg_local_ip  = cfg.local_ip;
  assign cfg_remote_ip = cfg.remote_ip;
  assign cfg_src_port  = cfg.src_port;
  assign cfg_dst_port  = cfg.dst_port;
  assign cfg_soft_rst  = soft_rst_reg;

  // ---------------- status and counters ----------------
  logic [31:0] status_word;
  logic [31:0] counts_word;
  logic        unused_ok;

  always_comb begin
    status_word                   = '0;
    status_word[STAT_LINK_UP_BIT] = st_link_up;
    status_word[STAT_ARP_BIT]     = st_arp_resolved;
    status_word[STAT_RX_OVF_BIT]  = rx_ovf_reg;
  end

`ifdef ETH_UDP_REGS_STATS_EN
  localparam int CW = (C_CNT_WIDTH > 16) ? 16 : C_CNT_WIDTH;

  logic [CW-1:0] cnt_val [2];
  logic [1:0]    cnt_ev;
  assign cnt_ev = {ev_rx_pkt, ev_tx_pkt};

  for (gi = 0; gi < 2; gi++) begin : g_pkt_cnt
    eth_udp_evt_cnt #(.WIDTH(CW)) u_cnt (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .clr   (cnt_clr),
      .inc   (cnt_ev[gi]),
      .count (cnt_val[gi])
    );
  end

  assign counts_word = {16'(cnt_val[1]), 16'(cnt_val[0])};
  assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], awaddr_reg[1:0]};
`else
  assign counts_word = '0;
  assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], awaddr_reg[1:0],
                         ev_tx_pkt, ev_rx_pkt, cnt_clr, C_CNT_WIDTH[0]};
`endif

  // ---------------- read channel ----------------
  rd_state_t   rd_state_reg, rd_state_next;
  logic        arready_reg, arready_next;
  logic        rvalid_reg, rvalid_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case ({S_AXI_ARADDR[4:2], 2'b00})
      REG_CTRL:      rd_mux = word_val[word_idx(REG_CTRL)];
      REG_MAC_LO:    rd_mux = word_val[word_idx(REG_MAC_LO)];
      REG_MAC_HI:    rd_mux = word_val[word_idx(REG_MAC_HI)];
      REG_LOCAL_IP:  rd_mux = word_val[word_idx(REG_LOCAL_IP)];
      REG_REMOTE_IP: rd_mux = word_val[word_idx(REG_REMOTE_IP)];
      REG_PORTS:     rd_mux = word_val[word_idx(REG_PORTS)];
      REG_STATUS:    rd_mux = status_word;
      REG_COUNTS:    rd_mux = counts_word;
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rvalid_next   = rvalid_reg;
    rdata_next    = rdata_reg;
    case (rd_state_reg)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_reg) begin
          rdata_next    = rd_mux;
          rvalid_next   = 1'b1;
          rd_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_next   = 1'b0;
          rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
    arready_next = (rd_state_next == R_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      arready_reg  <= arready_next;
      rvalid_reg   <= rvalid_next;
      rdata_reg    <= rdata_next;
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_eth_udp_axil_regs.sv
// Self-checking bench: directed register-map scenarios plus randomized traffic against a word-level model.
module tb_eth_udp_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        cfg_enable, cfg_loopback, cfg_soft_rst;
  logic [47:0] cfg_local_mac;
  logic [31:0] cfg_local_ip, cfg_remote_ip;
  logic [15:0] cfg_src_port, cfg_dst_port;
  logic        st_link_up, st_arp_resolved;
  logic        ev_rx_overflow, ev_tx_pkt, ev_rx_pkt;

  eth_udp_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cfg_enable(cfg_enable), .cfg_loopback(cfg_loopback), .cfg_soft_rst(cfg_soft_rst),
    .cfg_local_mac(cfg_local_mac), .cfg_local_ip(cfg_local_ip), .cfg_remote_ip(cfg_remote_ip),
    .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
    .st_link_up(st_link_up), .st_arp_resolved(st_arp_resolved),
    .ev_rx_overflow(ev_rx_overflow), .ev_tx_pkt(ev_tx_pkt), .ev_rx_pkt(ev_rx_pkt)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  int soft_cnt = 0;

  always @(negedge ACLK) if (cfg_soft_rst) soft_cnt++;

  // Reference model: architectural register contents only.
  logic [31:0] m_word [6];
  bit          m_ovf;
  int          m_tx, m_rx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m_word[i] = '0;
    m_ovf = 0;
    m_tx  = 0;
    m_rx  = 0;
  endfunction

  function automatic void model_write(input logic [4:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int          idx;
    logic [31:0] v;
    idx = int'(addr[4:2]);
    if (idx < 6) begin
      v = m_word[idx];
      for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
      if (idx == 0) v = v & 32'h0000_0003;
      if (idx == 2) v = v & 32'h0000_FFFF;
      m_word[idx] = v;
    end else if (idx == 6) begin
      if (strb[0] && data[2]) m_ovf = 0;
    end else begin
      m_tx = 0;
      m_rx = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    int idx;
    idx = int'(addr[4:2]);
    if (idx < 6) return m_word[idx];
    if (idx == 6) return {29'b0, m_ovf, st_arp_resolved, st_link_up};
`ifdef ETH_UDP_REGS_STATS_EN
    return {16'(m_rx), 16'(m_tx)};
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_cfg();
    check("cfg_enable",    cfg_enable,    m_word[0][0]);
    check("cfg_loopback",  cfg_loopback,  m_word[0][1]);
    check("cfg_local_mac", cfg_local_mac, {m_word[2][15:0], m_word[1]});
    check("cfg_local_ip",  cfg_local_ip,  m_word[3]);
    check("cfg_remote_ip", cfg_remote_ip, m_word[4]);
    check("cfg_src_port",  cfg_src_port,  m_word[5][31:16]);
    check("cfg_dst_port",  cfg_dst_port,  m_word[5][15:0]);
  endtask

  // w_lead > 0: W leads AW by w_lead cycles; < 0: AW leads. commit_ev = {rx_pkt, tx_pkt, rx_ovf}
  // is raised in the cycle after both handshakes, i.e. the cycle in which the register updates.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_delay, input logic [2:0] commit_ev);
    bit aw_done, w_done, hs_aw, hs_w, early_b, hold_ok;
    int cyc;
    aw_done = 0; w_done = 0; early_b = 0; cyc = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (!aw_done && cyc >= w_lead)  S_AXI_AWVALID = 1'b1;
      if (!w_done  && cyc >= -w_lead) S_AXI_WVALID  = 1'b1;
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (hs_aw) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_done  = 1; S_AXI_WVALID  = 1'b0; end
      if (S_AXI_BVALID && !(aw_done && w_done)) early_b = 1;
      cyc++;
    end
    check("wr_handshake", aw_done && w_done, 1);
    if (!(aw_done && w_done)) begin
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      return;
    end
    check("wr_no_early_b", early_b, 0);
    if (commit_ev != 3'b000) begin
      {ev_rx_pkt, ev_tx_pkt, ev_rx_overflow} = commit_ev;
      @(posedge ACLK); @(negedge ACLK);
      {ev_rx_pkt, ev_tx_pkt, ev_rx_overflow} = 3'b000;
    end
    cyc = 0;
    while (!S_AXI_BVALID && cyc < 20) begin
      @(posedge ACLK); @(negedge ACLK);
      cyc++;
    end
    check("bvalid", S_AXI_BVALID, 1);
    check("bresp", S_AXI_BRESP, 2'b00);
    hold_ok = 1;
    repeat (b_delay) begin
      @(posedge ACLK); @(negedge ACLK);
      hold_ok &= S_AXI_BVALID && !S_AXI_AWREADY && !S_AXI_WREADY;
    end
    if (b_delay > 0) check("b_hold", hold_ok, 1);
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("b_single", S_AXI_BVALID, 0);
    model_write(addr, data, strb);
    if (commit_ev[0]) m_ovf = 1;
    if (commit_ev[1]) m_tx++;
    if (commit_ev[2]) m_rx++;
    $display("WR addr=0x%02h data=0x%08h strb=%b lead=%0d", addr, data, strb, w_lead);
  endtask

  task automatic axi_read(input logic [4:0] addr, input int r_delay, output logic [31:0] data);
    bit hs, done, hold_ok;
    int cyc;
    done = 0; cyc = 0; data = '0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!done && cyc < 50) begin
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (hs) begin done = 1; S_AXI_ARVALID = 1'b0; end
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    check("ar_handshake", done, 1);
    check("rvalid_lat1", S_AXI_RVALID, 1);
    check("rresp", S_AXI_RRESP, 2'b00);
    data = S_AXI_RDATA;
    hold_ok = 1;
    repeat (r_delay) begin
      @(posedge ACLK); @(negedge ACLK);
      hold_ok &= S_AXI_RVALID && (S_AXI_RDATA == data) && !S_AXI_ARREADY;
    end
    if (r_delay > 0) check("r_hold", hold_ok, 1);
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check("r_single", S_AXI_RVALID, 0);
    $display("RD addr=0x%02h data=0x%08h", addr, data);
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input int r_delay);
    logic [31:0] d;
    axi_read(addr, r_delay, d);
    check(tag, d, model_read(addr));
  endtask

  task automatic pulse(input logic [2:0] ev);
    {ev_rx_pkt, ev_tx_pkt, ev_rx_overflow} = ev;
    @(posedge ACLK); @(negedge ACLK);
    {ev_rx_pkt, ev_tx_pkt, ev_rx_overflow} = 3'b000;
    if (ev[0]) m_ovf = 1;
    if (ev[1]) m_tx++;
    if (ev[2]) m_rx++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, S_AXI_AWREADY, 0);
    check({tag, "_wready"},  S_AXI_WREADY,  0);
    check({tag, "_arready"}, S_AXI_ARREADY, 0);
    check({tag, "_bvalid"},  S_AXI_BVALID,  0);
    check({tag, "_rvalid"},  S_AXI_RVALID,  0);
  endtask

  initial begin
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          soft_before, lead;
    bit          no_b;

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    st_link_up = 1'b1; st_arp_resolved = 1'b0;
    ev_rx_overflow = 1'b0; ev_tx_pkt = 1'b0; ev_rx_pkt = 1'b0;
    model_reset();

    repeat (3) @(negedge ACLK);
    check_idle_outputs("reset");
    check("reset_soft_rst", cfg_soft_rst, 0);
    check_cfg();
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Basic write/readback and MAC composition.
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, 3'b000);
    axi_write(5'h04, 32'h2, 4'hF, 0, 0, 3'b000);
    axi_write(5'h08, 32'h3, 4'hF, 0, 0, 3'b000);
    axi_write(5'h0C, 32'h4, 4'hF, 0, 0, 3'b000);
    read_check("rd_ctrl",   5'h00, 0);
    read_check("rd_mac_lo", 5'h04, 0);
    read_check("rd_mac_hi", 5'h08, 0);
    read_check("rd_lip",    5'h0C, 0);
    check("plan_enable", cfg_enable, 1);
    check("plan_mac", cfg_local_mac, 48'h0003_0000_0002);

    // W three cycles ahead of AW.
    axi_write(5'h14, 32'hC350_1F90, 4'hF, 3, 0, 3'b000);
    check("plan_src_port", cfg_src_port, 16'hC350);
    check("plan_dst_port", cfg_dst_port, 16'h1F90);

    // Partial byte strobes over a zero register.
    axi_write(5'h10, 32'h0, 4'hF, -2, 0, 3'b000);
    axi_write(5'h10, 32'hAABB_CCDD, 4'b0101, 0, 0, 3'b000);
    read_check("rd_strb", 5'h10, 0);
    check("plan_strb", cfg_remote_ip, 32'h00BB_00DD);

    // Sticky overflow, W1C, and W1C losing to a coincident event.
    pulse(3'b001);
    read_check("ovf_set", 5'h18, 0);
    axi_write(5'h18, 32'h4, 4'hF, 0, 0, 3'b000);
    read_check("ovf_w1c", 5'h18, 0);
    axi_write(5'h18, 32'h4, 4'hF, 0, 0, 3'b001);
    read_check("ovf_set_wins", 5'h18, 0);
    axi_write(5'h18, 32'hFFFF_FFFB, 4'hF, 0, 0, 3'b000);
    read_check("status_ro", 5'h18, 0);

    // Soft reset pulse.
    soft_before = soft_cnt;
    axi_write(5'h00, 32'h8000_0001, 4'hF, 0, 0, 3'b000);
    repeat (2) @(negedge ACLK);
    check("soft_rst_cycles", soft_cnt - soft_before, 1);
    read_check("ctrl_after_soft", 5'h00, 0);

    // Back-pressure on B and R.
    axi_write(5'h0C, 32'h1234_5678, 4'hF, 0, 10, 3'b000);
    read_check("rd_stall", 5'h0C, 10);

    // Packet counters (read as 0 unless the statistics build is selected).
    axi_write(5'h1C, 32'h0, 4'hF, 0, 0, 3'b000);
    repeat (5) pulse(3'b010);
    repeat (3) pulse(3'b100);
    read_check("counts", 5'h1C, 0);
    axi_write(5'h1C, 32'h0, 4'h0, 0, 0, 3'b010);
    read_check("counts_clr_ev", 5'h1C, 0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      addr = 5'({$urandom_range(0, 7), 2'($urandom_range(0, 3))});
      if ($urandom_range(0, 3) == 0) begin
        st_link_up = 1'($urandom); st_arp_resolved = 1'($urandom);
      end
      if ($urandom_range(0, 4) == 0) pulse(3'($urandom_range(1, 7)));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        lead = $urandom_range(0, 6) - 3;
        axi_write(addr, data, strb, lead, $urandom_range(0, 2), 3'b000);
        check_cfg();
      end else begin
        read_check("rand_rd", addr, $urandom_range(0, 2));
      end
    end

    // Reset in the middle of a write: AW latched, W never sent.
    S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    S_AXI_ARVALID = 1'b0;
    check_idle_outputs("midrst");
    model_reset();
    check_cfg();
    @(negedge ACLK);
    ARESETN = 1'b1;
    no_b = 1;
    repeat (5) begin
      @(posedge ACLK); @(negedge ACLK);
      no_b &= !S_AXI_BVALID && !S_AXI_RVALID;
    end
    check("midrst_no_resp", no_b, 1);
    axi_write(5'h10, 32'hDEAD_BEEF, 4'hF, 1, 0, 3'b000);
    read_check("midrst_lip", 5'h0C, 0);
    read_check("midrst_rip", 5'h10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_udp_axil_regs.md
Name: eth_udp_axil_regs

Overview:
- AXI4-Lite slave register file that configures the Ethernet/ARP/UDP stack and reports its status; it is the stage an AXI4-Lite master drives.
- Holds the local MAC, local IP, remote IP and UDP ports, plus control bits. It drives these as static configuration to the stack datapath.
- Samples live status and sticky event flags from the stack. Optional packet counters are readable over the same bus.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width, giving 8 word registers.
- C_CNT_WIDTH, 32, width of the packet counters (1..32); the upper bits read as 0.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- S_AXI_AWADDR  in  5  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  always 2'b00
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  5  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always 2'b00
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
- cfg_enable, cfg_loopback  out  1  CTRL bits
- cfg_soft_rst  out  1  one-cycle pulse
- cfg_local_mac  out  48  local MAC address
- cfg_local_ip, cfg_remote_ip  out  32  IP addresses
- cfg_src_port, cfg_dst_port  out  16  UDP ports
- st_link_up, st_arp_resolved  in  1  live status
- ev_rx_overflow  in  1  one-cycle event
- ev_tx_pkt, ev_rx_pkt  in  1  one-cycle packet events (used only with the optional feature)

Behaviour:
- Register map (word address = ADDR[4:2]; ADDR[1:0] ignored):
  - 0x00 CTRL: [0] enable, [1] loopback, [31] soft_rst (write 1 -> pulse for 1 cycle, reads 0).
  - 0x04 MAC_LO [31:0].
  - 0x08 MAC_HI [15:0]; [31:16] read 0.
  - 0x0C LOCAL_IP.
  - 0x10 REMOTE_IP.
  - 0x14 PORTS: [31:16] src, [15:0] dst.
  - 0x18 STATUS: [0] link_up (RO), [1] arp_resolved (RO), [2] rx_overflow (sticky, W1C).
  - 0x1C COUNTS (RO).
- Reset values:
  - All registers, cfg_* outputs and the sticky bit are 0.
  - All READY and VALID outputs are 0.
- Write path, FSM states W_IDLE, W_RESP:
  - AWREADY=1 while no address is latched and the FSM is in W_IDLE. WREADY=1 while no data is latched and the FSM is in W_IDLE.
  - AW and W may arrive in any order or in the same cycle; each is latched independently.
  - When both are latched, the register is updated per WSTRB byte in that cycle, BVALID is asserted the next cycle, and the FSM moves to W_RESP.
  - BVALID holds until BREADY; both latches clear and the FSM returns to W_IDLE.
  - Throughput is at most one write per 2 cycles.
- Read path, FSM states R_IDLE, R_DATA:
  - ARREADY=1 in R_IDLE.
  - On the AR handshake, RDATA is registered and RVALID=1 the next cycle (latency 1).
  - RDATA and RVALID hold stable until RREADY, then the FSM returns to R_IDLE.
- Writes to RO bits are ignored.
- Concurrent read and write:
  - A read and a write in the same cycle to the same register: the read returns the pre-write value.
  - A W1C of rx_overflow coinciding with ev_rx_overflow: the set wins and the bit stays 1.
- cfg_local_mac = {MAC_HI[15:0], MAC_LO}.
- Reset asserted mid-transaction immediately clears all VALID and READY outputs and the latched AW/W; no response is issued for aborted transfers.

Optional Feature:
- Macro ETH_UDP_REGS_STATS_EN.
- Defined:
  - COUNTS = {rx_cnt[15:0], tx_cnt[15:0]}.
  - The counters increment on ev_rx_pkt and ev_tx_pkt respectively and wrap modulo 2^16.
  - Any write to 0x1C clears both counters. An event in the same cycle as the clear leaves the counter at 1.
- Undefined: COUNTS reads 0, no counter flops exist, and the ev_tx_pkt/ev_rx_pkt inputs are unused.

Decomposition:
- Package eth_udp_regs_pkg holds:
  - register offset localparams (REG_CTRL .. REG_COUNTS);
  - STATUS and CTRL bit-index constants;
  - OKAY response constant;
  - a typedef for the config bundle struct.
- One sub-module, eth_udp_evt_cnt, implements the saturating-free wrap counter with synchronous clear (instantiated twice under the macro).

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> 0x1,0x2,0x3,0x4; cfg_enable=1, cfg_local_mac=48'h0003_00000002, BRESP=RRESP=0.
- Drive W 3 cycles before AW for 0x14 = 0xC350_1F90 -> single BVALID after AW; cfg_src_port=0xC350, cfg_dst_port=0x1F90.
- Write 0xAABBCCDD to 0x10 with WSTRB=4'b0101 over a prior 0 -> reads 0x00BB00DD.
- Pulse ev_rx_overflow, read 0x18 -> bit2=1. Write 0x4 to 0x18 -> reads 0. Repeat the W1C coinciding with an event -> bit2 stays 1.
- Write CTRL=0x8000_0001 -> cfg_soft_rst high for exactly 1 cycle; CTRL reads 0x1.
- Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID and RDATA stable, AWREADY and ARREADY stay 0. With ETH_UDP_REGS_STATS_EN: 5 ev_tx_pkt and 3 ev_rx_pkt -> COUNTS=0x0003_0005.
